// File: rtl/uart_rx_if.sv
// Consumer-side handshake bundle for uart_rx: received byte, status flags and acknowledge.
// ParityErr is present only when UART_RX_PARITY_EN is defined.
interface uart_rx_if;
  logic [7:0] Dout;
  logic       Receive;
  logic       FrameErr;
  logic       Overrun;
  logic       Busy;
  logic       ReceiveAck;
`ifdef UART_RX_PARITY_EN
  logic       ParityErr;
`endif

  modport master (
`ifdef UART_RX_PARITY_EN
    output ParityErr,
`endif
    output Dout, Receive, FrameErr, Overrun, Busy,
    input  ReceiveAck
  );

  modport slave (
`ifdef UART_RX_PARITY_EN
    input  ParityErr,
`endif
    input  Dout, Receive, FrameErr, Overrun, Busy,
    output ReceiveAck
  );
endinterface

// File: rtl/uart_rx.sv
// UART receiver: 8N1 frames, mid-bit sampling, level/ack handshake with sticky error flags.
// Define UART_RX_PARITY_EN to insert an odd-parity bit between data and stop (adds ParityErr).
module uart_rx #(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      Sin,
  uart_rx_if.master rx
);

  localparam int BAUD_TICKS = CLK_FREQUENCY / BAUD_RATE;
  localparam int CNT_W      = $clog2(BAUD_TICKS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BAUD_TICKS - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(BAUD_TICKS / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_RX_PARITY_EN
    ODD_PARITY,
`endif
    STOP
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_cnt_q;
  logic [7:0]       shift_q;
  logic             sync1_q, sin_s;

  // Sample strobes produced by the next-state logic
  logic shift_en, capture, frame_err_set;
`ifdef UART_RX_PARITY_EN
  logic par_err_set;
`endif

  // Synchronizer resets to the idle line level so reset release never looks like a start bit.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      sin_s   <= 1'b1;
    end else begin
      // NOTE: sequential state uses <= so every flop sees pre-edge values, keeping the two stages distinct.
      sync1_q <= Sin;
      sin_s   <= sync1_q;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  always_comb begin
    // NOTE: every output of this block is defaulted first; a missing branch would otherwise infer a latch.
    state_d       = state_q;
    shift_en      = 1'b0;
    capture       = 1'b0;
    frame_err_set = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_err_set   = 1'b0;
`endif
    unique case (state_q)
      IDLE:  if (!sin_s) state_d = START;
      START: if (cnt_q == CNT_HALF) state_d = sin_s ? IDLE : DATA;
      DATA: begin
        if (cnt_q == CNT_LAST) begin
          shift_en = 1'b1;
`ifdef UART_RX_PARITY_EN
          if (bit_cnt_q == 3'd7) state_d = ODD_PARITY;
`else
          if (bit_cnt_q == 3'd7) state_d = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      ODD_PARITY: begin
        if (cnt_q == CNT_LAST) begin
          par_err_set = ~(^shift_q ^ sin_s);
          state_d     = STOP;
        end
      end
`endif
      STOP: begin
        if (cnt_q == CNT_LAST) begin
          capture       = sin_s;
          frame_err_set = ~sin_s;
          state_d       = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Counter restarts on each state entry and on each completed bit period within DATA.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q     <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
    end else begin
      if (state_q == IDLE || state_d != state_q || cnt_q == CNT_LAST) cnt_q <= '0;
      else                                                           cnt_q <= cnt_q + 1'b1;

      if (state_q == START)  bit_cnt_q <= '0;
      else if (shift_en)     bit_cnt_q <= bit_cnt_q + 1'b1;

      if (shift_en) shift_q <= {sin_s, shift_q[7:1]};
    end
  end

  // Acknowledge clears first; a capture or error on the same edge then takes precedence.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rx.Dout      <= 8'h00;
      rx.Receive   <= 1'b0;
      rx.FrameErr  <= 1'b0;
      rx.Overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
      rx.ParityErr <= 1'b0;
`endif
    end else begin
      if (rx.ReceiveAck) begin
        rx.Receive   <= 1'b0;
        rx.FrameErr  <= 1'b0;
        rx.Overrun   <= 1'b0;
`ifdef UART_RX_PARITY_EN
        rx.ParityErr <= 1'b0;
`endif
      end
      if (capture) begin
        rx.Dout    <= shift_q;
        rx.Receive <= 1'b1;
        rx.Overrun <= rx.Overrun | (rx.Receive & ~rx.ReceiveAck);
      end
      if (frame_err_set) rx.FrameErr <= 1'b1;
`ifdef UART_RX_PARITY_EN
      if (par_err_set) rx.ParityErr <= 1'b1;
`endif
    end
  end

  assign rx.Busy = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx at 16 clocks per bit: reset, single frame with latency,
// glitch, framing error, overrun with and without same-cycle ack, and a byte series.
module tb_uart_rx;

  localparam int B = 16;
`ifdef UART_RX_PARITY_EN
  localparam int NB  = 11;
  localparam int CAP = 170;
`else
  localparam int NB  = 10;
  localparam int CAP = 154;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic Sin = 1'b1;
  int   n_checks = 0;
  int   n_fail = 0;

  uart_rx_if rx_if ();

  uart_rx #(.CLK_FREQUENCY(100_000_000), .BAUD_RATE(6_250_000)) dut (
    .clk   (clk),
    .reset (rst_n),
    .Sin   (Sin),
    .rx    (rx_if.master)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drives one frame; ack_at selects the loop index whose following edge carries ReceiveAck.
  // rx_pre/rx_post hold Receive just before and just after the expected capture edge.
  task automatic send_frame(input logic [7:0] data, input logic stop, input logic par_flip,
                            input int ack_at, output logic rx_pre, output logic rx_post);
    logic [10:0] bits;
    bits = '1;
    bits[0]   = 1'b0;
    bits[8:1] = data;
`ifdef UART_RX_PARITY_EN
    bits[9]  = ~(^data) ^ par_flip;
    bits[10] = stop;
`else
    bits[9]  = stop;
`endif
    rx_pre  = 1'b0;
    rx_post = 1'b0;
    @(posedge clk);
    #1;
    for (int c = 0; c < NB * B; c++) begin
      Sin = bits[c / B];
      rx_if.ReceiveAck = (c == ack_at);
      @(posedge clk);
      #1;
      if (c == CAP - 1) rx_pre = rx_if.Receive;
      if (c == CAP)     rx_post = rx_if.Receive;
    end
    rx_if.ReceiveAck = 1'b0;
    Sin = 1'b1;
  endtask

  task automatic ack_pulse();
    rx_if.ReceiveAck = 1'b1;
    cycles(1);
    rx_if.ReceiveAck = 1'b0;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    cycles(2);
    rst_n = 1'b1;
    cycles(2);
  endtask

  logic pre, post;
  logic [7:0] loop_bytes [3];

  initial begin
    rx_if.ReceiveAck = 1'b0;
    loop_bytes[0] = 8'h00;
    loop_bytes[1] = 8'hFF;
    loop_bytes[2] = 8'h55;

    // Reset state
    cycles(3);
    rst_n = 1'b1;
    cycles(3);
    check("rst_dout",    32'(rx_if.Dout), 32'h00);
    check("rst_receive", 32'(rx_if.Receive), 0);
    check("rst_frameerr", 32'(rx_if.FrameErr), 0);
    check("rst_overrun", 32'(rx_if.Overrun), 0);
    check("rst_busy",    32'(rx_if.Busy), 0);

    // Reset asserted mid-DATA aborts immediately
    Sin = 1'b0;
    cycles(40);
    check("mid_busy_before", 32'(rx_if.Busy), 1);
    #2 rst_n = 1'b0;
    #1;
    check("mid_busy_async", 32'(rx_if.Busy), 0);
    check("mid_receive",    32'(rx_if.Receive), 0);
    Sin = 1'b1;
    cycles(3);
    rst_n = 1'b1;
    cycles(2 * B);
    check("mid_after_busy",    32'(rx_if.Busy), 0);
    check("mid_after_receive", 32'(rx_if.Receive), 0);

    // Single frame with capture-edge latency and ack
    send_frame(8'hA5, 1'b1, 1'b0, -1, pre, post);
    check("a5_rx_before_cap", 32'(pre), 0);
    check("a5_rx_at_cap",     32'(post), 1);
    check("a5_dout",          32'(rx_if.Dout), 32'hA5);
    check("a5_frameerr",      32'(rx_if.FrameErr), 0);
    check("a5_busy",          32'(rx_if.Busy), 0);
    ack_pulse();
    check("a5_ack_receive",   32'(rx_if.Receive), 0);
    ack_pulse();
    check("idle_ack_receive", 32'(rx_if.Receive), 0);
    check("idle_ack_dout",    32'(rx_if.Dout), 32'hA5);

    // Glitch shorter than half a bit is rejected
    Sin = 1'b0;
    cycles(B / 4);
    Sin = 1'b1;
    cycles(2);
    check("glitch_busy_start", 32'(rx_if.Busy), 1);
    cycles(B);
    check("glitch_busy_end", 32'(rx_if.Busy), 0);
    check("glitch_receive",  32'(rx_if.Receive), 0);
    check("glitch_frameerr", 32'(rx_if.FrameErr), 0);
    check("glitch_overrun",  32'(rx_if.Overrun), 0);

    // Stop bit driven low
    send_frame(8'h3C, 1'b0, 1'b0, -1, pre, post);
    cycles(2 * B);
    check("ferr_frameerr", 32'(rx_if.FrameErr), 1);
    check("ferr_receive",  32'(rx_if.Receive), 0);
    check("ferr_dout",     32'(rx_if.Dout), 32'hA5);
    check("ferr_busy",     32'(rx_if.Busy), 0);
    do_reset();

    // Back-to-back frames without ack
    send_frame(8'h11, 1'b1, 1'b0, -1, pre, post);
    send_frame(8'h22, 1'b1, 1'b0, -1, pre, post);
    check("ovr_dout",    32'(rx_if.Dout), 32'h22);
    check("ovr_receive", 32'(rx_if.Receive), 1);
    check("ovr_overrun", 32'(rx_if.Overrun), 1);
    ack_pulse();
    check("ovr_ack_overrun", 32'(rx_if.Overrun), 0);
    check("ovr_ack_receive", 32'(rx_if.Receive), 0);

    // Ack on the capture edge of the second byte: capture wins, no overrun
    send_frame(8'h11, 1'b1, 1'b0, -1, pre, post);
    check("ovr2_first_receive", 32'(rx_if.Receive), 1);
    send_frame(8'h22, 1'b1, 1'b0, CAP, pre, post);
    check("ovr2_dout",    32'(rx_if.Dout), 32'h22);
    check("ovr2_receive", 32'(rx_if.Receive), 1);
    check("ovr2_overrun", 32'(rx_if.Overrun), 0);
    ack_pulse();

    // Byte series
    for (int i = 0; i < 3; i++) begin
      send_frame(loop_bytes[i], 1'b1, 1'b0, -1, pre, post);
      check($sformatf("loop%0d_dout", i), 32'(rx_if.Dout), 32'(loop_bytes[i]));
      check($sformatf("loop%0d_receive", i), 32'(rx_if.Receive), 1);
      check($sformatf("loop%0d_flags", i), 32'({rx_if.FrameErr, rx_if.Overrun}), 0);
`ifdef UART_RX_PARITY_EN
      check($sformatf("loop%0d_parerr", i), 32'(rx_if.ParityErr), 0);
`endif
      ack_pulse();
    end

`ifdef UART_RX_PARITY_EN
    send_frame(8'h55, 1'b1, 1'b1, -1, pre, post);
    check("par_parerr",  32'(rx_if.ParityErr), 1);
    check("par_dout",    32'(rx_if.Dout), 32'h55);
    check("par_receive", 32'(rx_if.Receive), 1);
    ack_pulse();
    check("par_ack_parerr", 32'(rx_if.ParityErr), 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- UART receiver; the stage directly downstream of the transmitter.
- Consumes the serial line driven by the transmitter, recovers 8-bit frames (1 start bit, 8 data bits LSB first, 1 stop bit), and presents each byte with a level/acknowledge handshake.
- Used for loopback checking of the transmitter and as the host-to-board receive path.

Parameters:
- CLK_FREQUENCY, 100_000_000: system clock frequency in Hz.
- BAUD_RATE, 19_200: line rate in bits/s.
- BAUD_TICKS, CLK_FREQUENCY/BAUD_RATE (5208 at defaults): clocks per bit; derived locally, not overridden.

Ports:
- clk  input  1  system clock; all state changes on its rising edge.
- reset  input  1  asynchronous, active-low reset; 0 clears all state immediately.
- Sin  input  1  serial line, asynchronous to clk; idle level 1.
- ReceiveAck  input  1  consumer acknowledge; clears Receive and the flags.
- Dout  output  8  last successfully received byte.
- Receive  output  1  high from byte capture until acknowledged.
- FrameErr  output  1  a stop bit was sampled as 0; sticky until ReceiveAck.
- Overrun  output  1  a byte was captured while Receive was already high; sticky until ReceiveAck.
- Busy  output  1  high whenever the FSM is not in IDLE.

Behaviour:
- Input sync: Sin passes through a 2-FF synchronizer. Both flops reset to 1. All sampling uses the synchronized value sin_s.
- Reset values: Dout=0x00, Receive=0, FrameErr=0, Overrun=0, Busy=0, FSM=IDLE, baud counter=0, bit counter=0.
- Reset mid-frame: the FSM aborts to IDLE asynchronously. No partial byte is ever presented.
- Baud counter: counts 0..BAUD_TICKS-1. Cleared on every state entry. Never wraps into the next state without an explicit transition.
- FSM states and transitions:
  - IDLE: on sin_s=0, go to START and clear the counter.
  - START: when counter = BAUD_TICKS/2-1 (mid start bit), sample sin_s.
    - sample=1: false start; return to IDLE with no flag set.
    - sample=0: go to DATA with bit counter=0.
  - DATA: when counter = BAUD_TICKS-1 (mid data bit), shift sin_s into shift[7] (right shift, so LSB ends in bit 0) and increment the bit counter. After the 8th sample, go to STOP.
  - STOP: when counter = BAUD_TICKS-1, sample sin_s and go to IDLE.
    - sample=1: Dout<=shift and Receive<=1. If Receive was already 1 and ReceiveAck is not high that cycle, also set Overrun<=1.
    - sample=0: FrameErr<=1; Dout and Receive are unchanged.
- Latency: Receive rises one clk after the stop-bit sample, about 2 + BAUD_TICKS/2 + 9*BAUD_TICKS clocks after the falling edge of Sin.
- Handshake:
  - ReceiveAck=1 for one or more cycles clears Receive, FrameErr and Overrun on the next edge.
  - If ReceiveAck and a capture land on the same cycle, the capture wins: Receive stays 1, and Overrun stays 0 unless already set.
  - ReceiveAck while Receive=0 has no effect.
- Back-to-back frames: returning to IDLE at mid-stop leaves half a bit period to detect the next start edge. Continuous 0 after a framing error is handled as follows: IDLE sees 0, enters START, and re-synchronizes.
- Busy is combinational from the FSM state: 0 only in IDLE.

Optional Feature:
- Macro: UART_RX_PARITY_EN.
- Defined:
  - An ODD_PARITY state is inserted between DATA and STOP.
  - The parity bit is sampled at mid-bit, expecting odd parity (XOR of data bits and parity bit equals 1).
  - Adds port ParityErr (output, 1), reset 0.
  - Mismatch: ParityErr<=1, sticky, cleared by ReceiveAck. The byte is still captured at STOP if the stop bit is valid.
  - Frame becomes 11 bits; latency grows by BAUD_TICKS.
- Undefined: no parity state and no ParityErr port; 10-bit frames only.

Test Plan:
- Reset: hold reset=0 with Sin=1, release -> all outputs 0, Busy=0; reassert reset=0 mid-DATA -> Busy=0 immediately and Receive stays 0.
- Single frame 0xA5 at 19200 baud, 100 MHz -> Receive=1 with Dout=0xA5 about 9.5*5208 clocks after the start edge; FrameErr=0. ReceiveAck pulse -> Receive=0 next cycle.
- Glitch: Sin low for 1000 clocks then high -> FSM returns to IDLE, Receive=0, no flag set.
- Framing error: frame 0x3C with stop bit driven 0 -> FrameErr=1, Receive=0, Dout keeps its prior value.
- Overrun: two back-to-back frames 0x11, 0x22 with no ack -> Dout=0x22, Receive=1, Overrun=1. Repeat with ack on the capture cycle of 0x22 -> Overrun=0.
- Loopback: transmitter output tied to Sin, send 0x00, 0xFF, 0x55 -> Dout matches each byte; with UART_RX_PARITY_EN, a corrupted parity bit on 0x55 -> ParityErr=1 and Dout=0x55.
